// File: rtl/stream_src_sel_mon.sv
// stream_src_sel_mon
// N-way stream source selector with a registered output stage, a
// drain-before-switch FSM and built-in handshake monitors.
// A source change waits until the output register is empty or fires. This
// means no beat is lost, duplicated or mixed between sources.
// Parameter constraints: NUM_SRC >= 2, INIT_SEL < NUM_SRC.

module stream_src_sel_mon #(
    parameter int NUM_SRC     = 2,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 32,
    parameter int INIT_SEL    = 0,
    parameter int STALL_LIMIT = 1024,
    localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,

    input  logic [SEL_W-1:0]          sel_req,
    input  logic                      sel_req_vld,

    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    output logic [NUM_SRC-1:0]        s_tready,

    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,

    output logic [SEL_W-1:0]          cur_sel,
    output logic                      switching,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          xfer_cnt,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic                      stall_flag,
    input  logic                      cnt_clr
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [SEL_W:0]    NUM_SRC_V  = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0]  INIT_SEL_V = SEL_W'(INIT_SEL);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(STALL_LIMIT - 1);

    state_t              state;
    logic [SEL_W-1:0]    pend_sel;
    logic [SEL_W-1:0]    next_pend;
    logic [DATA_W-1:0]   cur_data;
    logic                out_free;
    logic                load;
    logic                fire;
    logic                stall;
    logic                req_in_range;
    logic                req_ok;
    logic                req_bad;

    // Output-register handshake terms.
    assign out_free = ~m_tvalid | m_tready;
    assign fire     = m_tvalid & m_tready;
    assign stall    = m_tvalid & ~m_tready;

    // Request classification. The index is widened by one bit, so an
    // out-of-range value is caught even when NUM_SRC is a power of two.
    assign req_in_range = ({1'b0, sel_req} < NUM_SRC_V);
    assign req_ok       = sel_req_vld & req_in_range;
    assign req_bad      = sel_req_vld & ~req_in_range;

    // Latest in-range request wins, including one that arrives in the exit cycle.
    assign next_pend = req_ok ? sel_req : pend_sel;

    assign switching = (state == ST_DRAIN);

    // Data mux for the currently selected source.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                cur_data = s_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready goes only to the active source in RUN, and only while the output register can take a beat.
    // It is also held low while reset is asserted, so no source sees a handshake during reset.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tready[i] = ap_rst_n && (state == ST_RUN) && out_free
                          && (cur_sel == SEL_W'(i));
        end
    end

    // At most one ready bit is set, so this reduces to a single-source handshake.
    assign load = |(s_tready & s_tvalid);

    // Registered output stage: one-cycle latency, one beat per cycle.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= cur_data;
        end else if (out_free) begin
            m_tvalid <= 1'b0;
        end
    end

    // Selection FSM: RUN accepts requests; DRAIN waits until the held beat leaves.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_RUN;
            cur_sel  <= INIT_SEL_V;
            pend_sel <= INIT_SEL_V;
        end else begin
            case (state)
                ST_RUN: begin
                    if (req_ok && (sel_req != cur_sel)) begin
                        pend_sel <= sel_req;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pend_sel <= next_pend;
                    if (!m_tvalid || m_tready) begin
                        cur_sel <= next_pend;
                        state   <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Sticky out-of-range request flag; a clear overrides a coincident set.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sel_err <= 1'b0;
        end else if (cnt_clr) begin
            sel_err <= 1'b0;
        end else if (req_bad) begin
            sel_err <= 1'b1;
        end
    end

    // Saturating count of beats leaving the output register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            xfer_cnt <= '0;
        end else if (cnt_clr) begin
            xfer_cnt <= '0;
        end else if (fire && (xfer_cnt != CNT_MAX)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    // Length of the current backpressure run; it restarts at zero on any non-stall cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr || !stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Sticky flag: set on the cycle the stall run reaches STALL_LIMIT.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_flag <= 1'b0;
        end else if (cnt_clr) begin
            stall_flag <= 1'b0;
        end else if (stall && (stall_cnt == STALL_LAST)) begin
            stall_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_src_sel_mon.sv
// Directed testbench for stream_src_sel_mon.
// The main instance has three sources, so index 3 is out of range, and STALL_LIMIT = 8.
// A second instance has CNT_W = 4 to exercise counter saturation.

module tb_stream_src_sel_mon;

    localparam int NS = 3;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int SW = 2;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b1;

    // main instance
    logic [SW-1:0]    sel_req;
    logic             sel_req_vld;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [SW-1:0]    cur_sel;
    logic             switching;
    logic             sel_err;
    logic [CW-1:0]    xfer_cnt;
    logic [CW-1:0]    stall_cnt;
    logic             stall_flag;
    logic             cnt_clr;

    // saturation instance
    logic [0:0]  z_sel_req;
    logic        z_sel_req_vld;
    logic [15:0] z_tdata;
    logic [1:0]  z_tvalid;
    logic [1:0]  z_tready;
    logic [7:0]  z_m_tdata;
    logic        z_m_tvalid;
    logic        z_m_tready;
    logic [0:0]  z_cur_sel;
    logic        z_switching;
    logic        z_sel_err;
    logic [3:0]  z_xfer_cnt;
    logic [3:0]  z_stall_cnt;
    logic        z_stall_flag;
    logic        z_cnt_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ap_clk = ~ap_clk;

    stream_src_sel_mon #(
        .NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW), .INIT_SEL(0), .STALL_LIMIT(8)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .sel_req(sel_req), .sel_req_vld(sel_req_vld),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .cur_sel(cur_sel), .switching(switching), .sel_err(sel_err),
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt), .stall_flag(stall_flag),
        .cnt_clr(cnt_clr)
    );

    stream_src_sel_mon #(
        .NUM_SRC(2), .DATA_W(8), .CNT_W(4), .INIT_SEL(0), .STALL_LIMIT(4)
    ) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .sel_req(z_sel_req), .sel_req_vld(z_sel_req_vld),
        .s_tdata(z_tdata), .s_tvalid(z_tvalid), .s_tready(z_tready),
        .m_tdata(z_m_tdata), .m_tvalid(z_m_tvalid), .m_tready(z_m_tready),
        .cur_sel(z_cur_sel), .switching(z_switching), .sel_err(z_sel_err),
        .xfer_cnt(z_xfer_cnt), .stall_cnt(z_stall_cnt), .stall_flag(z_stall_flag),
        .cnt_clr(z_cnt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        sel_req       = '0;
        sel_req_vld   = 1'b0;
        s_tdata       = '0;
        s_tvalid      = '1;
        m_tready      = 1'b1;
        cnt_clr       = 1'b0;
        z_sel_req     = '0;
        z_sel_req_vld = 1'b0;
        z_tdata       = '0;
        z_tvalid      = '0;
        z_m_tready    = 1'b0;
        z_cnt_clr     = 1'b0;

        // ---- reset values (s_tvalid/m_tready high so ready gating is visible)
        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_m_tvalid",   32'(m_tvalid),   0);
        check("rst_m_tdata",    m_tdata,         0);
        check("rst_cur_sel",    32'(cur_sel),    0);
        check("rst_switching",  32'(switching),  0);
        check("rst_sel_err",    32'(sel_err),    0);
        check("rst_xfer_cnt",   xfer_cnt,        0);
        check("rst_stall_cnt",  stall_cnt,       0);
        check("rst_stall_flag", 32'(stall_flag), 0);
        check("rst_s_tready",   32'(s_tready),   0);
        check("rst_z_xfer",     32'(z_xfer_cnt), 0);
        s_tvalid = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
        tick();

        // ---- 1: beats 1..100 from source 0, continuous ready
        m_tready = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            s_tdata[0 +: DW] = 32'(k);
            s_tvalid[0]      = 1'b1;
            #1;
            check("t1_rdy0", 32'(s_tready[0]), 1);
            check("t1_rdy1", 32'(s_tready[1]), 0);
            tick();
            check("t1_data", m_tdata, 32'(k));
            check("t1_vld",  32'(m_tvalid), 1);
        end
        s_tvalid[0] = 1'b0;
        tick();
        check("t1_empty", 32'(m_tvalid), 0);
        check("t1_hold",  m_tdata, 100);
        check("t1_xfer",  xfer_cnt, 100);

        // ---- 2: switch 0 -> 1 while the output is stalled for 5 cycles
        m_tready         = 1'b0;
        s_tdata[0 +: DW] = 32'h200;
        s_tvalid[0]      = 1'b1;
        s_tdata[DW +: DW] = 32'h1000;
        s_tvalid[1]      = 1'b1;
        tick();
        check("t2_load", m_tdata, 32'h200);
        s_tdata[0 +: DW] = 32'h201;
        sel_req          = 2'd1;
        sel_req_vld      = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        check("t2_sw",     32'(switching), 1);
        check("t2_cursel", 32'(cur_sel),   0);
        for (int i = 2; i <= 5; i++) begin
            #1;
            check("t2_rdy_drain", 32'(s_tready), 0);
            tick();
            check("t2_sw_hold",  32'(switching), 1);
            check("t2_data_hold", m_tdata, 32'h200);
            check("t2_vld_hold", 32'(m_tvalid), 1);
        end
        check("t2_stall5", stall_cnt, 5);
        m_tready = 1'b1;
        #1;
        check("t2_rdy_fire", 32'(s_tready), 0);
        tick();
        check("t2_sw_done",  32'(switching), 0);
        check("t2_cursel1",  32'(cur_sel),   1);
        check("t2_bubble",   32'(m_tvalid),  0);
        check("t2_xfer101",  xfer_cnt,       101);
        check("t2_stall0",   stall_cnt,      0);
        s_tvalid[0] = 1'b0;
        #1;
        check("t2_rdy_new", 32'(s_tready), 2);
        tick();
        check("t2_src1", m_tdata, 32'h1000);
        check("t2_vld1", 32'(m_tvalid), 1);
        s_tvalid[1] = 1'b0;
        tick();
        check("t2_xfer102", xfer_cnt, 102);
        check("t2_empty",   32'(m_tvalid), 0);

        // ---- 3: out-of-range and same-source requests do not disturb the stream
        for (int k = 0; k < 6; k++) begin
            s_tdata[DW +: DW] = 32'h300 + 32'(k);
            s_tvalid[1]       = 1'b1;
            sel_req_vld       = (k == 2) || (k == 4);
            sel_req           = (k == 2) ? 2'd3 : 2'd1;
            tick();
            sel_req_vld = 1'b0;
            check("t3_data",   m_tdata, 32'h300 + 32'(k));
            check("t3_vld",    32'(m_tvalid),  1);
            check("t3_nosw",   32'(switching), 0);
            check("t3_cursel", 32'(cur_sel),   1);
        end
        s_tvalid[1] = 1'b0;
        tick();
        check("t3_sel_err", 32'(sel_err), 1);
        check("t3_xfer",    xfer_cnt, 108);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t3_err_clr",  32'(sel_err), 0);
        check("t3_xfer_clr", xfer_cnt, 0);

        // ---- 4: stall of STALL_LIMIT cycles
        m_tready          = 1'b0;
        s_tdata[DW +: DW] = 32'h400;
        s_tvalid[1]       = 1'b1;
        tick();
        s_tvalid[1] = 1'b0;
        check("t4_stall_start", stall_cnt, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t4_stall_cnt",  stall_cnt, 32'(i));
            check("t4_stall_flag", 32'(stall_flag), (i == 8) ? 1 : 0);
        end
        m_tready = 1'b1;
        tick();
        check("t4_stall_rel",  stall_cnt, 0);
        check("t4_flag_stick", 32'(stall_flag), 1);
        check("t4_fired",      32'(m_tvalid), 0);
        check("t4_xfer",       xfer_cnt, 1);

        // ---- 5a: clear coincident with a fire wins; data path unaffected
        s_tdata[DW +: DW] = 32'h500;
        s_tvalid[1]       = 1'b1;
        tick();
        s_tvalid[1] = 1'b0;
        cnt_clr     = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t5_clr_xfer", xfer_cnt, 0);
        check("t5_clr_flag", 32'(stall_flag), 0);
        check("t5_clr_vld",  32'(m_tvalid), 0);
        check("t5_clr_data", m_tdata, 32'h500);

        // ---- 5b: CNT_W = 4 saturation
        z_m_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            z_tdata[7:0] = 8'(k + 1);
            z_tvalid[0]  = 1'b1;
            tick();
            check("t5_sat_data", 32'(z_m_tdata), 32'(k + 1));
            check("t5_sat_cnt",  32'(z_xfer_cnt), (k < 15) ? 32'(k) : 15);
        end
        z_tvalid[0] = 1'b0;
        tick();
        check("t5_sat_final", 32'(z_xfer_cnt), 15);
        z_tdata[7:0] = 8'hAA;
        z_tvalid[0]  = 1'b1;
        tick();
        z_tvalid[0] = 1'b0;
        z_cnt_clr   = 1'b1;
        tick();
        z_cnt_clr = 1'b0;
        check("t5_sat_clr",  32'(z_xfer_cnt), 0);
        check("t5_sat_vld",  32'(z_m_tvalid), 0);
        check("t5_sat_sel",  32'(z_cur_sel),  0);
        check("t5_sat_sw",   32'(z_switching), 0);
        check("t5_sat_err",  32'(z_sel_err),  0);
        check("t5_sat_stl",  32'(z_stall_cnt), 0);
        check("t5_sat_flg",  32'(z_stall_flag), 0);
        check("t5_sat_rdy",  32'(z_tready), 1);

        // ---- 6: asynchronous reset while in DRAIN
        m_tready          = 1'b0;
        s_tdata[DW +: DW] = 32'h600;
        s_tvalid[1]       = 1'b1;
        tick();
        s_tvalid[1] = 1'b0;
        sel_req     = 2'd2;
        sel_req_vld = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        check("t6_pre_sw",    32'(switching), 1);
        check("t6_pre_vld",   32'(m_tvalid),  1);
        check("t6_pre_stall", stall_cnt, 1);
        #2 ap_rst_n = 1'b0;
        s_tvalid = '1;
        m_tready = 1'b1;
        #1;
        check("t6_rst_vld",    32'(m_tvalid),  0);
        check("t6_rst_sel",    32'(cur_sel),   0);
        check("t6_rst_sw",     32'(switching), 0);
        check("t6_rst_stall",  stall_cnt, 0);
        check("t6_rst_xfer",   xfer_cnt,  0);
        check("t6_rst_data",   m_tdata,   0);
        check("t6_rst_rdy",    32'(s_tready), 0);
        tick();
        check("t6_rst_rdy_edge", 32'(s_tready), 0);
        check("t6_rst_vld_edge", 32'(m_tvalid), 0);
        s_tvalid         = 3'b001;
        s_tdata[0 +: DW] = 32'h700;
        #2 ap_rst_n = 1'b1;
        #1;
        check("t6_rel_rdy", 32'(s_tready), 1);
        tick();
        check("t6_rel_data", m_tdata, 32'h700);
        check("t6_rel_sel",  32'(cur_sel), 0);
        s_tvalid = '0;
        tick();
        check("t6_rel_xfer", xfer_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
